// File: rtl/rca_pkg.sv
// Shared types and helpers for the pipelined ripple-carry adder/subtractor.
// Stage sideband flags live here; the width-dependent payload is built in the top.
package rca_pkg;

    typedef struct packed {
        logic valid;
        logic carry;
        logic sign_a;
        logic sign_bb;
        logic ovf;
    } stage_flags_t;

    function automatic int chunk_width(input int w, input int stages);
        return (stages > 0) ? (w / stages) : w;
    endfunction

endpackage

// File: rtl/rca_chunk.sv
// Combinational N-bit ripple-carry adder built from full-adder cells.
module rca_chunk #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);

    logic [N:0] c_s;

    assign c_s[0] = ci;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign s[i]     = a[i] ^ b[i] ^ c_s[i];
        assign c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
    end

    assign co = c_s[N];

endmodule

// File: rtl/rca_pipe_addsub.sv
// Pipelined W-bit ripple-carry adder/subtractor: each stage ripples one CHUNK
// and registers its carry; the whole pipe advances on a single valid/ready enable.
module rca_pipe_addsub
    import rca_pkg::*;
#(
    parameter int W      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf,
    output logic [W:0]   out
);

    localparam int CHUNK  = chunk_width(W, STAGES);
    localparam bit CFG_OK = (STAGES >= 1) && ((W % ((STAGES >= 1) ? STAGES : 1)) == 0);

    if (!CFG_OK) begin : g_bad_cfg
        $error("rca_pipe_addsub: W must be a positive multiple of STAGES");
    end

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] bb;
        logic [W-1:0] sum;
        stage_flags_t fl;
    } stage_t;

    stage_t entry_s;
    stage_t stage_d [STAGES];
    stage_t stage_q [STAGES];
    logic   adv_s;

    // Beat as seen by stage 0: subtraction becomes a + ~b + 1.
    always_comb begin
        entry_s            = '0;
        entry_s.a          = a;
        entry_s.bb         = sub ? ~b : b;
        entry_s.fl.valid   = in_valid;
        entry_s.fl.carry   = sub ? 1'b1 : cin;
        entry_s.fl.sign_a  = a[W-1];
        entry_s.fl.sign_bb = entry_s.bb[W-1];
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t           src_s;
        stage_t           nxt_s;
        logic [CHUNK-1:0] chunk_sum_s;
        logic             chunk_co_s;

        if (k == 0) begin : g_src
            assign src_s = entry_s;
        end else begin : g_src
            assign src_s = stage_q[k-1];
        end

        rca_chunk #(.N(CHUNK)) u_chunk (
            .a  (src_s.a[k*CHUNK +: CHUNK]),
            .b  (src_s.bb[k*CHUNK +: CHUNK]),
            .ci (src_s.fl.carry),
            .s  (chunk_sum_s),
            .co (chunk_co_s)
        );

        // Merge this chunk into the running sum; ovf is only meaningful once the MSB chunk is done.
        always_comb begin
            nxt_s                           = src_s;
            nxt_s.sum[k*CHUNK +: CHUNK]     = chunk_sum_s;
            nxt_s.fl.carry                  = chunk_co_s;
            nxt_s.fl.ovf                    = (src_s.fl.sign_a == src_s.fl.sign_bb) &&
                                              (nxt_s.sum[W-1] != src_s.fl.sign_a);
        end

        assign stage_d[k] = nxt_s;
    end

    // Whole-pipe advance: a stalled output freezes every stage, so bubbles are never collapsed.
    always_comb begin
        adv_s = !stage_q[STAGES-1].fl.valid || out_ready;
    end

    // Stage registers; reset discards every in-flight beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else if (adv_s) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i];
            end
        end
    end

    assign in_ready  = adv_s;
    assign out_valid = stage_q[STAGES-1].fl.valid;
    assign sum       = stage_q[STAGES-1].sum;
    assign cout      = stage_q[STAGES-1].fl.carry;
    assign ovf       = stage_q[STAGES-1].fl.ovf;
    assign out       = {stage_q[STAGES-1].fl.carry, stage_q[STAGES-1].sum};

endmodule

// File: tb/tb_rca_pipe_addsub.sv
// Self-checking bench for rca_pipe_addsub: three configurations against an
// arithmetic reference model, plus a randomized stalling stream and mid-stream reset.
module tb_rca_pipe_addsub;

    logic clk;
    logic rst_n;

    // DUT0: W=8, STAGES=2
    logic        d0_in_valid, d0_in_ready, d0_cin, d0_sub, d0_out_valid, d0_out_ready;
    logic [7:0]  d0_a, d0_b, d0_sum;
    logic        d0_cout, d0_ovf;
    logic [8:0]  d0_out;
    // DUT1: W=8, STAGES=4
    logic        d1_in_valid, d1_in_ready, d1_cin, d1_sub, d1_out_valid, d1_out_ready;
    logic [7:0]  d1_a, d1_b, d1_sum;
    logic        d1_cout, d1_ovf;
    logic [8:0]  d1_out;
    // DUT2: W=16, STAGES=1
    logic        d2_in_valid, d2_in_ready, d2_cin, d2_sub, d2_out_valid, d2_out_ready;
    logic [15:0] d2_a, d2_b, d2_sum;
    logic        d2_cout, d2_ovf;
    logic [16:0] d2_out;

    int checks   = 0;
    int failures = 0;

    rca_pipe_addsub #(.W(8), .STAGES(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(d0_in_valid), .in_ready(d0_in_ready),
        .a(d0_a), .b(d0_b), .cin(d0_cin), .sub(d0_sub), .out_valid(d0_out_valid),
        .out_ready(d0_out_ready), .sum(d0_sum), .cout(d0_cout), .ovf(d0_ovf), .out(d0_out)
    );

    rca_pipe_addsub #(.W(8), .STAGES(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
        .a(d1_a), .b(d1_b), .cin(d1_cin), .sub(d1_sub), .out_valid(d1_out_valid),
        .out_ready(d1_out_ready), .sum(d1_sum), .cout(d1_cout), .ovf(d1_ovf), .out(d1_out)
    );

    rca_pipe_addsub #(.W(16), .STAGES(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
        .a(d2_a), .b(d2_b), .cin(d2_cin), .sub(d2_sub), .out_valid(d2_out_valid),
        .out_ready(d2_out_ready), .sum(d2_sum), .cout(d2_cout), .ovf(d2_ovf), .out(d2_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands, signed range test for overflow.
    function automatic void ref_model(input int w, input logic [31:0] a, input logic [31:0] b,
                                      input logic cin, input logic sub,
                                      output logic [31:0] s, output logic c, output logic o);
        longint m, half, ua, ub, sa, sb, full, st;
        m    = longint'(1) << w;
        half = m / 2;
        ua   = longint'(a);
        ub   = longint'(b);
        sa   = (ua >= half) ? ua - m : ua;
        sb   = (ub >= half) ? ub - m : ub;
        if (sub) begin
            full = ua - ub + m;
            c    = (ua >= ub);
            st   = sa - sb;
        end else begin
            full = ua + ub + longint'(cin);
            c    = (full >= m);
            st   = sa + sb + longint'(cin);
        end
        s = 32'(full % m);
        o = (st >= half) || (st < -half);
    endfunction

    task automatic dir0(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sub);
        logic [31:0] es;
        logic        ec, eo;
        ref_model(8, 32'(a), 32'(b), cin, sub, es, ec, eo);
        @(negedge clk);
        d0_a = a; d0_b = b; d0_cin = cin; d0_sub = sub;
        d0_in_valid = 1'b1; d0_out_ready = 1'b1;
        @(negedge clk);
        d0_in_valid = 1'b0;
        #1;
        check_eq({tag, "_early"}, 32'(d0_out_valid), 32'(1'b0));
        @(negedge clk);
        #1;
        check_eq({tag, "_vld"},  32'(d0_out_valid), 32'(1'b1));
        check_eq({tag, "_sum"},  32'(d0_sum), es);
        check_eq({tag, "_cout"}, 32'(d0_cout), 32'(ec));
        check_eq({tag, "_ovf"},  32'(d0_ovf), 32'(eo));
        check_eq({tag, "_out"},  32'(d0_out), 32'({ec, es[7:0]}));
    endtask

    task automatic dir1(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sub);
        logic [31:0] es;
        logic        ec, eo;
        ref_model(8, 32'(a), 32'(b), cin, sub, es, ec, eo);
        @(negedge clk);
        d1_a = a; d1_b = b; d1_cin = cin; d1_sub = sub; d1_in_valid = 1'b1;
        @(negedge clk);
        d1_in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_eq({tag, "_early"}, 32'(d1_out_valid), 32'(1'b0));
        @(negedge clk);
        #1;
        check_eq({tag, "_vld"},  32'(d1_out_valid), 32'(1'b1));
        check_eq({tag, "_sum"},  32'(d1_sum), es);
        check_eq({tag, "_cout"}, 32'(d1_cout), 32'(ec));
        check_eq({tag, "_ovf"},  32'(d1_ovf), 32'(eo));
    endtask

    // Back-to-back beats through the single-stage 16-bit configuration.
    task automatic thru2();
        logic [15:0] va [4];
        logic [15:0] vb [4];
        logic        vc [4];
        logic [31:0] es;
        logic        ec, eo;
        va[0] = 16'hFFFF; vb[0] = 16'hFFFF; vc[0] = 1'b1;
        for (int i = 1; i < 4; i++) begin
            va[i] = 16'($urandom); vb[i] = 16'($urandom); vc[i] = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            #1;
            if (i > 0) begin
                ref_model(16, 32'(va[i-1]), 32'(vb[i-1]), vc[i-1], 1'b0, es, ec, eo);
                check_eq("w16_vld",  32'(d2_out_valid), 32'(1'b1));
                check_eq("w16_sum",  32'(d2_sum), es);
                check_eq("w16_cout", 32'(d2_cout), 32'(ec));
                check_eq("w16_ovf",  32'(d2_ovf), 32'(eo));
            end
            if (i < 4) begin
                d2_a = va[i]; d2_b = vb[i]; d2_cin = vc[i]; d2_sub = 1'b0; d2_in_valid = 1'b1;
            end else begin
                d2_in_valid = 1'b0;
            end
        end
    endtask

    // Random stream with a pseudo-random out_ready; queue scoreboard plus stall checks.
    task automatic stream0();
        logic [31:0] q [$];
        logic [31:0] es, held, exp_word;
        logic        ec, eo, stall_prev;
        int          sent, rcvd, cyc;
        sent = 0; rcvd = 0; cyc = 0; stall_prev = 1'b0; held = '0;
        while ((sent < 10 || q.size() > 0) && cyc < 300) begin
            @(negedge clk);
            cyc++;
            d0_out_ready = (sent < 10) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sent < 10) begin
                d0_in_valid = ($urandom_range(0, 3) != 0);
                d0_a = 8'($urandom); d0_b = 8'($urandom);
                d0_cin = 1'($urandom_range(0, 1)); d0_sub = 1'($urandom_range(0, 1));
            end else begin
                d0_in_valid = 1'b0;
            end
            #1;
            check_eq("strm_rdy", 32'(d0_in_ready), 32'(!(d0_out_valid && !d0_out_ready)));
            if (stall_prev) begin
                check_eq("strm_hold", 32'({d0_out_valid, d0_ovf, d0_out}), held);
            end
            if (d0_out_valid && d0_out_ready && q.size() > 0) begin
                exp_word = q.pop_front();
                check_eq("strm_res", 32'({d0_ovf, d0_cout, d0_sum}), exp_word);
                rcvd++;
            end else if (d0_out_valid && d0_out_ready) begin
                rcvd++;
            end
            if (d0_in_valid && d0_in_ready) begin
                ref_model(8, 32'(d0_a), 32'(d0_b), d0_cin, d0_sub, es, ec, eo);
                q.push_back(32'({eo, ec, es[7:0]}));
                sent++;
            end
            stall_prev = d0_out_valid && !d0_out_ready;
            held       = 32'({d0_out_valid, d0_ovf, d0_out});
        end
        check_eq("strm_sent", 32'(sent), 32'(10));
        check_eq("strm_count", 32'(rcvd), 32'(sent));
        check_eq("strm_drain", 32'(q.size()), 32'(0));
        @(negedge clk);
        d0_in_valid = 1'b0; d0_out_ready = 1'b1;
    endtask

    task automatic reset_mid0();
        @(negedge clk);
        d0_a = 8'h12; d0_b = 8'h34; d0_cin = 1'b0; d0_sub = 1'b0;
        d0_in_valid = 1'b1; d0_out_ready = 1'b0;
        @(negedge clk);
        d0_a = 8'h55; d0_b = 8'h11;
        @(negedge clk);
        d0_in_valid = 1'b0;
        #1;
        check_eq("rst_pre_vld", 32'(d0_out_valid), 32'(1'b1));
        check_eq("rst_pre_sum", 32'(d0_sum), 32'(8'h46));
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("rst_async_vld",  32'(d0_out_valid), 32'(1'b0));
        check_eq("rst_async_out",  32'(d0_out), 32'(9'h000));
        check_eq("rst_async_ovf",  32'(d0_ovf), 32'(1'b0));
        check_eq("rst_async_rdy",  32'(d0_in_ready), 32'(1'b1));
        @(negedge clk);
        rst_n = 1'b1;
        d0_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check_eq("rst_post_idle", 32'(d0_out_valid), 32'(1'b0));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        d0_in_valid = 1'b0; d0_a = '0; d0_b = '0; d0_cin = 1'b0; d0_sub = 1'b0; d0_out_ready = 1'b1;
        d1_in_valid = 1'b0; d1_a = '0; d1_b = '0; d1_cin = 1'b0; d1_sub = 1'b0; d1_out_ready = 1'b1;
        d2_in_valid = 1'b0; d2_a = '0; d2_b = '0; d2_cin = 1'b0; d2_sub = 1'b0; d2_out_ready = 1'b1;
        #2;
        check_eq("rst0_vld", 32'(d0_out_valid), 32'(1'b0));
        check_eq("rst0_rdy", 32'(d0_in_ready), 32'(1'b1));
        check_eq("rst0_out", 32'({d0_ovf, d0_out}), 32'(10'h000));
        check_eq("rst1_vld", 32'(d1_out_valid), 32'(1'b0));
        check_eq("rst2_out", 32'({d2_out_valid, d2_ovf, d2_out}), 32'(19'h00000));
        check_eq("rst2_rdy", 32'(d2_in_ready), 32'(1'b1));
        @(negedge clk);
        rst_n = 1'b1;

        dir0("add_ovf", 8'h3C, 8'h4A, 1'b0, 1'b0);
        dir0("carry_x", 8'hFF, 8'h01, 1'b1, 1'b0);
        dir0("sub_s2",  8'h05, 8'h07, 1'b0, 1'b1);
        dir1("sub_neg", 8'h05, 8'h07, 1'b0, 1'b1);
        dir1("sub_ovf", 8'h80, 8'h01, 1'b0, 1'b1);
        thru2();
        stream0();
        reset_mid0();
        dir0("post_rst", 8'hA5, 8'h5A, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
